// File: rtl/pick_angle_finder_pkg.sv
// Shared constants, FSM state type and the trig table generator for the pick-angle search.
package pick_pkg;

    localparam int PICK_BASE     = 489;
    localparam int PICK_MAX      = 600;
    localparam int QUARTER_STEPS = 112;
    localparam int SIN_OFFSET    = 112;
    localparam int TRIG_SCALE    = 1000;
    localparam int SEARCH_BITS   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPARE,
        ST_DONE
    } pickState_e;

    // Elaboration-time table value: a<112 gives cos, 112..223 gives sin via cos(90deg - angle).
    function automatic logic [9:0] trigValue(input int addr);
        longint scale;
        longint piFp;
        longint xFp;
        longint term;
        longint sum;
        longint val;
        int     idx;
        scale = longint'(1) << 28;
        piFp  = 64'd843314857;
        if (addr < QUARTER_STEPS) begin
            idx = addr;
        end else if (addr < 2 * QUARTER_STEPS) begin
            idx = 2 * QUARTER_STEPS - addr;
        end else begin
            idx = -1;
        end
        if (idx < 0) begin
            return 10'd0;
        end
        xFp  = longint'(idx) * piFp / longint'(2 * QUARTER_STEPS);
        term = scale;
        sum  = scale;
        for (int n = 1; n <= 8; n++) begin
            term = term * xFp / scale;
            term = term * xFp / scale;
            term = -term / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        val = (sum * longint'(TRIG_SCALE) + scale / 2) / scale;
        if (val < 0) begin
            val = 0;
        end
        return 10'(val);
    endfunction

endpackage

// File: rtl/pick_angle_finder_if.sv
// Request/result bundle between a pick-angle client and the finder.
interface pick_angle_finder_if;

    logic       start;
    logic [9:0] centerX;
    logic [9:0] centerY;
    logic [9:0] PointX;
    logic [9:0] PointY;
    logic       busy;
    logic       done;
    logic [9:0] PickX;
    logic [1:0] quadrant;
    logic       degenerate;

    modport master (
        output start, centerX, centerY, PointX, PointY,
        input  busy, done, PickX, quadrant, degenerate
    );

    modport slave (
        input  start, centerX, centerY, PointX, PointY,
        output busy, done, PickX, quadrant, degenerate
    );

endinterface

// File: rtl/pick_angle_finder_trig_lut.sv
// TrigLUT: quarter-wave cos table (0..111) followed by sin table (112..223), read with fixed latency.
module TrigLUT
    import pick_pkg::*;
#(
    parameter int ROM_LATENCY = 1
) (
    input  logic       CLK,
    input  logic [7:0] addr_i,
    output logic [9:0] q_o
);

    logic [9:0] romTable [256];
    logic [9:0] pipe_q [ROM_LATENCY];

    for (genvar i = 0; i < 256; i++) begin : gRom
        localparam logic [9:0] ENTRY = trigValue(i);
        assign romTable[i] = ENTRY;
    end

    always_ff @(posedge CLK) begin
        pipe_q[0] <= romTable[addr_i];
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[ROM_LATENCY-1];

endmodule

// File: rtl/pick_angle_finder.sv
// Recovers PickX/quadrant from a screen point by a 7-step successive-approximation search
// for the largest angle index k with tan(k) <= dy/dx.
module pick_angle_finder
    import pick_pkg::*;
#(
    parameter int ROM_LATENCY = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    pick_angle_finder_if.slave  bus
);

    localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    pickState_e  state_q, state_d;
    logic [9:0]  dx_q, dx_d;
    logic [9:0]  dy_q, dy_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  b_q, b_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]  quadWork_q, quadWork_d;
    logic        degenWork_q, degenWork_d;
    logic [9:0]  pickX_q, pickX_d;
    logic [1:0]  quadrant_q, quadrant_d;
    logic        degenerate_q, degenerate_d;

    logic [6:0]  cand;
    logic        candValid;
    logic [7:0]  cosAddr;
    logic [7:0]  sinAddr;
    logic [9:0]  cosQ;
    logic [9:0]  sinQ;
    logic [19:0] lhsProd;
    logic [19:0] rhsProd;
    logic        accept;
    logic [6:0]  kNext;

    assign cand      = k_q | (7'd1 << b_q);
    assign candValid = (cand <= 7'(QUARTER_STEPS - 1));
    assign cosAddr   = {1'b0, cand};
    assign sinAddr   = {1'b0, cand} + 8'(SIN_OFFSET);

    TrigLUT #(.ROM_LATENCY(ROM_LATENCY)) uCosLut (
        .CLK    (CLK),
        .addr_i (cosAddr),
        .q_o    (cosQ)
    );

    TrigLUT #(.ROM_LATENCY(ROM_LATENCY)) uSinLut (
        .CLK    (CLK),
        .addr_i (sinAddr),
        .q_o    (sinQ)
    );

    // A zero-length vector would otherwise satisfy every candidate; it must resolve to k=0.
    assign lhsProd = dy_q * cosQ;
    assign rhsProd = dx_q * sinQ;
    assign accept  = candValid && (lhsProd >= rhsProd) && !degenWork_q;
    assign kNext   = accept ? cand : k_q;

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        k_d          = k_q;
        b_d          = b_q;
        waitCnt_d    = waitCnt_q;
        quadWork_d   = quadWork_q;
        degenWork_d  = degenWork_q;
        pickX_d      = pickX_q;
        quadrant_d   = quadrant_q;
        degenerate_d = degenerate_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d        = (bus.PointX >= bus.centerX) ? (bus.PointX - bus.centerX)
                                                          : (bus.centerX - bus.PointX);
                dy_d        = (bus.PointY >= bus.centerY) ? (bus.PointY - bus.centerY)
                                                          : (bus.centerY - bus.PointY);
                quadWork_d  = {bus.PointY < bus.centerY, bus.PointX < bus.centerX};
                degenWork_d = (bus.PointX == bus.centerX) && (bus.PointY == bus.centerY);
                k_d         = 7'd0;
                b_d         = 3'(SEARCH_BITS - 1);
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                waitCnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (waitCnt_q == WAIT_W'(ROM_LATENCY - 1)) begin
                    state_d = ST_COMPARE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                k_d = kNext;
                if (b_q == 3'd0) begin
                    pickX_d      = 10'(PICK_BASE) + {3'b000, kNext};
                    quadrant_d   = quadWork_q;
                    degenerate_d = degenWork_q;
                    state_d      = ST_DONE;
                end else begin
                    b_d     = b_q - 3'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            dx_q         <= '0;
            dy_q         <= '0;
            k_q          <= '0;
            b_q          <= '0;
            waitCnt_q    <= '0;
            quadWork_q   <= '0;
            degenWork_q  <= 1'b0;
            pickX_q      <= 10'(PICK_BASE);
            quadrant_q   <= '0;
            degenerate_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            k_q          <= k_d;
            b_q          <= b_d;
            waitCnt_q    <= waitCnt_d;
            quadWork_q   <= quadWork_d;
            degenWork_q  <= degenWork_d;
            pickX_q      <= pickX_d;
            quadrant_q   <= quadrant_d;
            degenerate_q <= degenerate_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.PickX      = pickX_q;
    assign bus.quadrant   = quadrant_q;
    assign bus.degenerate = degenerate_q;

endmodule

// File: tb/tb_pick_angle_finder.sv
// Directed bench for pick_angle_finder: axis/diagonal points, degenerate input, ignored starts, mid-search reset.
module tb_pick_angle_finder;

    logic CLK;
    logic Reset;
    int   testsRun;
    int   testsFailed;

    pick_angle_finder_if bus ();

    pick_angle_finder #(.ROM_LATENCY(1)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one request; the accepting edge counts as cycle 1 and done is looked for after each later edge.
    task automatic runOp(input logic [9:0] cx, input logic [9:0] cy,
                         input logic [9:0] px, input logic [9:0] py,
                         input int pokeA, input int pokeB,
                         output int lat, output int nDone, output logic busyAfter,
                         output logic [9:0] pick, output logic [1:0] quad, output logic dg);
        int cnt;
        lat       = -1;
        nDone     = 0;
        busyAfter = 1'b1;
        pick      = '0;
        quad      = '0;
        dg        = 1'b0;
        @(negedge CLK);
        bus.centerX = cx;
        bus.centerY = cy;
        bus.PointX  = px;
        bus.PointY  = py;
        bus.start   = 1'b1;
        @(posedge CLK);
        cnt = 1;
        #1 bus.start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (cnt == pokeA || cnt == pokeB) begin
                bus.start = 1'b1;
            end
            @(posedge CLK);
            cnt++;
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                nDone++;
                if (lat < 0) begin
                    lat  = cnt;
                    pick = bus.PickX;
                    quad = bus.quadrant;
                    dg   = bus.degenerate;
                end
            end
            if (lat > 0 && cnt == lat + 1) begin
                busyAfter = bus.busy;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        testsRun++;
        if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        testsRun++;
        if (bus.PickX !== 10'd489) begin testsFailed++; $display("[TB] FAIL reset_pickx: got %0d expected 489", bus.PickX); end
        testsRun++;
        if (bus.quadrant !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_quadrant: got %0d expected 0", bus.quadrant); end
        testsRun++;
        if (bus.degenerate !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_degenerate: got %0b expected 0", bus.degenerate); end
    endtask

    task automatic test_horizontal();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd420, 10'd240, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (lat !== 23) begin testsFailed++; $display("[TB] FAIL horiz_latency: got %0d expected 23", lat); end
        testsRun++;
        if (pick !== 10'd489) begin testsFailed++; $display("[TB] FAIL horiz_pickx: got %0d expected 489", pick); end
        testsRun++;
        if (quad !== 2'd0) begin testsFailed++; $display("[TB] FAIL horiz_quadrant: got %0d expected 0", quad); end
        testsRun++;
        if (dg !== 1'b0) begin testsFailed++; $display("[TB] FAIL horiz_degenerate: got %0b expected 0", dg); end
        testsRun++;
        if (busyAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL horiz_busy_after_done: got %0b expected 0", busyAfter); end
    endtask

    task automatic test_vertical();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd320, 10'd340, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (pick !== 10'd600) begin testsFailed++; $display("[TB] FAIL vert_pickx: got %0d expected 600", pick); end
        testsRun++;
        if (quad !== 2'd0) begin testsFailed++; $display("[TB] FAIL vert_quadrant: got %0d expected 0", quad); end
        testsRun++;
        if (nDone !== 1) begin testsFailed++; $display("[TB] FAIL vert_done_count: got %0d expected 1", nDone); end
    endtask

    task automatic test_diagonal();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd420, 10'd340, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (pick !== 10'd545) begin testsFailed++; $display("[TB] FAIL diag_q0_pickx: got %0d expected 545", pick); end
        testsRun++;
        if (quad !== 2'd0) begin testsFailed++; $display("[TB] FAIL diag_q0_quadrant: got %0d expected 0", quad); end
        runOp(10'd320, 10'd240, 10'd220, 10'd340, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (pick !== 10'd545) begin testsFailed++; $display("[TB] FAIL diag_q1_pickx: got %0d expected 545", pick); end
        testsRun++;
        if (quad !== 2'd1) begin testsFailed++; $display("[TB] FAIL diag_q1_quadrant: got %0d expected 1", quad); end
        runOp(10'd320, 10'd240, 10'd220, 10'd140, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (pick !== 10'd545) begin testsFailed++; $display("[TB] FAIL diag_q3_pickx: got %0d expected 545", pick); end
        testsRun++;
        if (quad !== 2'd3) begin testsFailed++; $display("[TB] FAIL diag_q3_quadrant: got %0d expected 3", quad); end
    endtask

    task automatic test_degenerate();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd320, 10'd240, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (pick !== 10'd489) begin testsFailed++; $display("[TB] FAIL degen_pickx: got %0d expected 489", pick); end
        testsRun++;
        if (dg !== 1'b1) begin testsFailed++; $display("[TB] FAIL degen_flag: got %0b expected 1", dg); end
        testsRun++;
        if (quad !== 2'd0) begin testsFailed++; $display("[TB] FAIL degen_quadrant: got %0d expected 0", quad); end
        testsRun++;
        if (lat !== 23) begin testsFailed++; $display("[TB] FAIL degen_latency: got %0d expected 23", lat); end
    endtask

    task automatic test_busy_ignore();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd220, 10'd140, 5, 10, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (nDone !== 1) begin testsFailed++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", nDone); end
        testsRun++;
        if (lat !== 23) begin testsFailed++; $display("[TB] FAIL ignore_latency: got %0d expected 23", lat); end
        testsRun++;
        if (busyAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignore_busy_after_done: got %0b expected 0", busyAfter); end
        testsRun++;
        if (pick !== 10'd545) begin testsFailed++; $display("[TB] FAIL ignore_pickx: got %0d expected 545", pick); end
    endtask

    task automatic test_back_to_back();
        int lat, nDone;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        runOp(10'd320, 10'd240, 10'd320, 10'd340, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (lat !== 23) begin testsFailed++; $display("[TB] FAIL b2b_latency: got %0d expected 23", lat); end
        testsRun++;
        if (pick !== 10'd600) begin testsFailed++; $display("[TB] FAIL b2b_pickx: got %0d expected 600", pick); end
    endtask

    task automatic test_reset_midsearch();
        int cnt, nDone, lat;
        logic busyAfter, dg;
        logic [9:0] pick;
        logic [1:0] quad;
        nDone = 0;
        @(negedge CLK);
        bus.centerX = 10'd320;
        bus.centerY = 10'd240;
        bus.PointX  = 10'd420;
        bus.PointY  = 10'd340;
        bus.start   = 1'b1;
        @(posedge CLK);
        cnt = 1;
        #1 bus.start = 1'b0;
        while (cnt < 11) begin
            @(posedge CLK);
            cnt++;
            #1;
            if (bus.done) nDone++;
        end
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        testsRun++;
        if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %0b expected 0", bus.busy); end
        testsRun++;
        if (bus.PickX !== 10'd489) begin testsFailed++; $display("[TB] FAIL midrst_pickx: got %0d expected 489", bus.PickX); end
        testsRun++;
        if (bus.quadrant !== 2'd0) begin testsFailed++; $display("[TB] FAIL midrst_quadrant: got %0d expected 0", bus.quadrant); end
        Reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            if (bus.done) nDone++;
        end
        testsRun++;
        if (nDone !== 0) begin testsFailed++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", nDone); end
        runOp(10'd320, 10'd240, 10'd420, 10'd340, 0, 0, lat, nDone, busyAfter, pick, quad, dg);
        testsRun++;
        if (lat !== 23) begin testsFailed++; $display("[TB] FAIL midrst_restart_latency: got %0d expected 23", lat); end
        testsRun++;
        if (pick !== 10'd545) begin testsFailed++; $display("[TB] FAIL midrst_restart_pickx: got %0d expected 545", pick); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.start   = 1'b0;
        bus.centerX = '0;
        bus.centerY = '0;
        bus.PointX  = '0;
        bus.PointY  = '0;
        Reset       = 1'b1;
        test_reset();
        test_horizontal();
        test_vertical();
        test_diagonal();
        test_degenerate();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midsearch();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
